egr_rrs_responder: RTL
======================

# egr_rrs_responder

Responder end of the egress Read Response (RRS) protocol: accepts segment read requests from an RRS requestor (e.g. the Tag Queuing Unit), forwards them to the mesh read port, collects mesh read data, and returns responses to the requestor in request order, tagged with the requestor's ID. It sits between the egress partition's RRS requestors and the Mesh Read Interface. It bounds in-flight reads with an internal completion buffer so the mesh never returns data the block cannot hold.

## Interface
Parameters:
- ID_W, 8, request tag width
- ADDR_W, 20, segment pointer width
- DATA_W, 512, read data width (one 64B segment)
- DEPTH, 8, completion buffer entries; power of two, 2..32
- CNT_W, $clog2(DEPTH)+1, occupancy and pointer width (includes wrap bit)

Ports:
- clk  in  1  clock; sole clock domain
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_id  in  ID_W  requestor tag
- req_addr  in  ADDR_W  segment pointer
- mrd_valid  out  1  mesh read request valid
- mrd_ready  in  1  mesh accepts read
- mrd_addr  out  ADDR_W  mesh read address
- mrd_rsp_valid  in  1  mesh read data valid; in request order, no backpressure
- mrd_rsp_data  in  DATA_W  mesh read data
- mrd_rsp_err  in  1  mesh ECC/uncorrectable error for this beat
- rsp_valid  out  1  response valid
- rsp_ready  in  1  requestor accepts response
- rsp_id  out  ID_W  tag of returned request
- rsp_data  out  DATA_W  read data
- rsp_err  out  1  error forwarded from mesh
- occupancy  out  CNT_W  entries allocated and not yet returned
- protocol_err  out  1  sticky: mesh response received with nothing outstanding

## Operation
- Circular buffer of DEPTH entries {id, data, err, filled}; three pointers: alloc_ptr, fill_ptr, rd_ptr, each CNT_W bits with wrap bit.
- credit_ok = (alloc_ptr - rd_ptr) < DEPTH, from registered pointers only.
- Request path combinational: mrd_valid = req_valid && credit_ok; mrd_addr = req_addr; req_ready = mrd_ready && credit_ok.
- On request fire: entry[alloc_ptr].id <= req_id, filled <= 0, alloc_ptr++.
- On mrd_rsp_valid with fill_ptr != alloc_ptr: entry[fill_ptr].data/err written, filled <= 1, fill_ptr++.
- On mrd_rsp_valid with fill_ptr == alloc_ptr: beat dropped, protocol_err <= 1 (cleared only by rst).
- rsp_valid = entry[rd_ptr].filled && (rd_ptr != fill_ptr wrap-compare consistent); rsp_* driven from entry[rd_ptr]. On rsp fire: filled <= 0, rd_ptr++.
- rsp_valid, once asserted, holds with stable payload until rsp_ready.
- occupancy = alloc_ptr - rd_ptr (modulo 2^CNT_W).
- Pointer arithmetic wraps modulo 2^CNT_W; index = low $clog2(DEPTH) bits.

## Timing
- Request to mesh: 0 cycles (combinational through).
- Mesh response to rsp_valid: 1 cycle (filled bit registered).
- Back-to-back: one request and one response per cycle sustained when not full.
- Full (occupancy == DEPTH): req_ready = 0 even if rsp fires same cycle; freed credit visible next cycle.
- Simultaneous alloc, fill, pop in one cycle: all three legal, independent entries.
- Fill and pop same entry same cycle impossible (filled is registered).
- Reset: all pointers 0, all filled 0, rsp_valid 0, protocol_err 0, occupancy 0, mrd_valid 0, req_ready 0 during rst. In-flight mesh beats arriving after rst deassert with nothing outstanding set protocol_err; upstream is required to reset the mesh port concurrently.

## Structure
- egr_rrs_pkg: ID_W, ADDR_W, DATA_W constants; rrs_req_t {id, addr}; rrs_rsp_t {id, data, err} typedefs; shared with the requestor side.
- Sub-module egr_rrs_rsp_buf: DEPTH x (ID_W+DATA_W+1) storage, one id write port, one data write port, one async read port; pointers and control stay in egr_rrs_responder.

## Test plan
- Single request id=0x5A addr=0x00100, mesh returns data 0xA5.. after 3 cycles -> rsp_valid one cycle after mrd_rsp_valid, rsp_id=0x5A, rsp_err=0, occupancy 1->0 on pop.
- 8 back-to-back requests, mesh stalled on data, rsp_ready=1 -> 8 accepted, 9th sees req_ready=0, occupancy=8; after first mesh beat and pop, req_ready reasserts the following cycle.
- Variable mesh latency 1..10, rsp_ready random 50% -> responses in request order, ids and data match, no drops over 10k requests.
- mrd_rsp_err=1 on 3rd beat -> 3rd response rsp_err=1, others 0, ordering intact.
- mrd_rsp_valid with occupancy 0 -> no rsp_valid, protocol_err=1 and stays set until rst.
- rst asserted with 5 entries outstanding -> next cycle occupancy=0, rsp_valid=0, req_ready=1 once rst low and mrd_ready=1.

Source files
------------

// File: rtl/egr_rrs_pkg.sv
// Shared RRS protocol constants and payload types for the egress requestor and responder sides.
package egr_rrs_pkg;

  localparam int ID_W   = 8;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 512;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
  } rrs_req_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic              err;
  } rrs_rsp_t;

endpackage

// File: rtl/egr_rrs_rsp_buf.sv
// Completion buffer storage: id written at request time, data/err written when the mesh returns,
// read asynchronously at the head of the queue.
module egr_rrs_rsp_buf #(
  parameter int ID_W   = egr_rrs_pkg::ID_W,
  parameter int DATA_W = egr_rrs_pkg::DATA_W,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              id_we,
  input  logic [IDX_W-1:0]  id_waddr,
  input  logic [ID_W-1:0]   id_wdata,
  input  logic              data_we,
  input  logic [IDX_W-1:0]  data_waddr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic              err_wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [ID_W-1:0]   rd_id,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err
);

  logic [ID_W-1:0]   id_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  err_mem;

  always_ff @(posedge clk) begin
    if (id_we) id_mem[id_waddr] <= id_wdata;
    if (data_we) begin
      data_mem[data_waddr] <= data_wdata;
      err_mem[data_waddr]  <= err_wdata;
    end
  end

  assign rd_id   = id_mem[raddr];
  assign rd_data = data_mem[raddr];
  assign rd_err  = err_mem[raddr];

endmodule

// File: rtl/egr_rrs_responder.sv
// RRS responder: forwards segment reads to the mesh, buffers returned beats in request order
// and hands them back tagged with the requestor id. Credits bound in-flight reads to DEPTH.
module egr_rrs_responder #(
  parameter int ID_W   = egr_rrs_pkg::ID_W,
  parameter int ADDR_W = egr_rrs_pkg::ADDR_W,
  parameter int DATA_W = egr_rrs_pkg::DATA_W,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ID_W-1:0]   req_id,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              mrd_valid,
  input  logic              mrd_ready,
  output logic [ADDR_W-1:0] mrd_addr,
  input  logic              mrd_rsp_valid,
  input  logic [DATA_W-1:0] mrd_rsp_data,
  input  logic              mrd_rsp_err,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  occupancy,
  output logic              protocol_err
);

  localparam int               IDX_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] alloc_ptr, fill_ptr, rd_ptr, used;
  logic [IDX_W-1:0] alloc_idx, fill_idx, rd_idx;
  logic [DEPTH-1:0] filled;
  logic             credit_ok, req_fire, fill_fire, orphan_beat, rsp_fire;

  assign alloc_idx = alloc_ptr[IDX_W-1:0];
  assign fill_idx  = fill_ptr[IDX_W-1:0];
  assign rd_idx    = rd_ptr[IDX_W-1:0];

  // Credit comes from registered pointers only, so a pop this cycle frees space next cycle.
  assign used      = alloc_ptr - rd_ptr;
  assign credit_ok = used < DEPTH_C;
  assign occupancy = used;

  assign mrd_valid = req_valid && credit_ok && !rst;
  assign mrd_addr  = req_addr;
  assign req_ready = mrd_ready && credit_ok && !rst;
  assign req_fire  = req_valid && req_ready;

  assign fill_fire   = mrd_rsp_valid && (fill_ptr != alloc_ptr);
  assign orphan_beat = mrd_rsp_valid && (fill_ptr == alloc_ptr);

  assign rsp_valid = !rst && filled[rd_idx] && (rd_ptr != fill_ptr);
  assign rsp_fire  = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr    <= '0;
      fill_ptr     <= '0;
      rd_ptr       <= '0;
      filled       <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (req_fire)    alloc_ptr    <= alloc_ptr + ONE;
      if (fill_fire)   fill_ptr     <= fill_ptr + ONE;
      if (rsp_fire)    rd_ptr       <= rd_ptr + ONE;
      if (orphan_beat) protocol_err <= 1'b1;
      // alloc, fill and pop always address distinct entries, so these never collide.
      if (req_fire)  filled[alloc_idx] <= 1'b0;
      if (rsp_fire)  filled[rd_idx]    <= 1'b0;
      if (fill_fire) filled[fill_idx]  <= 1'b1;
    end
  end

  egr_rrs_rsp_buf #(
    .ID_W   (ID_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_buf (
    .clk        (clk),
    .id_we      (req_fire),
    .id_waddr   (alloc_idx),
    .id_wdata   (req_id),
    .data_we    (fill_fire),
    .data_waddr (fill_idx),
    .data_wdata (mrd_rsp_data),
    .err_wdata  (mrd_rsp_err),
    .raddr      (rd_idx),
    .rd_id      (rsp_id),
    .rd_data    (rsp_data),
    .rd_err     (rsp_err)
  );

endmodule
